// File: rtl/step_profile_gen.sv
// rtl/step_profile_gen.sv - queued stepper move generator with per-step linear period ramp
// Commands queue in a small FIFO; each move ramps the step period down, cruises, then ramps back up.

module spg_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = level[AW];
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module step_profile_gen #(
  parameter int DIV_W      = 20,
  parameter int CNT_W      = 16,
  parameter int POS_W      = 32,
  parameter int DIV_START  = 125000,
  parameter int DIV_DEC    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 100,
  parameter int DIR_SETUP  = 250
) (
  input  logic                          CLK_50MHZ,
  input  logic                          RST,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_dir,
  input  logic [CNT_W-1:0]              cmd_steps,
  input  logic [DIV_W-1:0]              cmd_div_max,
  input  logic                          abort,
  output logic                          step,
  output logic                          dir,
  output logic [POS_W-1:0]              cur_position,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CMD_W = 1 + CNT_W + DIV_W;
  localparam int SET_W = $clog2(DIR_SETUP + 1);
  localparam logic [DIV_W-1:0] START    = DIV_W'(DIV_START);
  localparam logic [DIV_W-1:0] DEC      = DIV_W'(DIV_DEC);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2 * PULSE_W);
  localparam logic [DIV_W-1:0] PW       = DIV_W'(PULSE_W);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, RUN, DONE} state_t;
  state_t state;

  logic             full, empty, pop, push;
  logic [CMD_W-1:0] head;
  logic             m_dir;
  logic [CNT_W-1:0] m_steps, remaining, ramp_cnt, rem_eff, next_ramp;
  logic [DIV_W-1:0] m_div, eff_max, divider, per_cnt, next_div;
  logic [DIV_W:0]   up_sum, dn_floor;
  logic [SET_W-1:0] set_cnt;
  logic             abort_pend;

  assign pop       = (state == IDLE) && !empty && !abort;
  assign cmd_ready = !abort && (!full || pop);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  spg_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK_50MHZ),
    .rst       (RST),
    .flush     (abort),
    .push      (push),
    .push_data ({cmd_dir, cmd_steps, cmd_div_max}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Abort shortens the move to just the steps needed to ramp back down.
  always_comb begin
    rem_eff = remaining;
    if ((abort_pend || abort) && (ramp_cnt < remaining)) rem_eff = ramp_cnt;
    up_sum    = {1'b0, divider} + {1'b0, DEC};
    dn_floor  = {1'b0, eff_max} + {1'b0, DEC};
    next_div  = divider;
    next_ramp = ramp_cnt;
    if (rem_eff <= ramp_cnt) begin
      next_div  = (up_sum > {1'b0, START}) ? START : up_sum[DIV_W-1:0];
      next_ramp = ramp_cnt - 1'b1;
    end else if (divider > eff_max) begin
      next_div  = ({1'b0, divider} > dn_floor) ? (divider - DEC) : eff_max;
      next_ramp = ramp_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state        <= IDLE;
      step         <= 1'b0;
      dir          <= 1'b0;
      cur_position <= '0;
      done         <= 1'b0;
      m_dir        <= 1'b0;
      m_steps      <= '0;
      m_div        <= '0;
      eff_max      <= MIN_DIV;
      divider      <= START;
      per_cnt      <= '0;
      remaining    <= '0;
      ramp_cnt     <= '0;
      set_cnt      <= '0;
      abort_pend   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (abort) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              {m_dir, m_steps, m_div} <= head;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (m_div < MIN_DIV)    eff_max <= MIN_DIV;
          else if (m_div > START) eff_max <= START;
          else                    eff_max <= m_div;
          divider    <= START;
          ramp_cnt   <= '0;
          remaining  <= m_steps;
          abort_pend <= 1'b0;
          set_cnt    <= '0;
          if ((m_steps == '0) || abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dir   <= m_dir;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (set_cnt == SET_LAST) begin
            state        <= RUN;
            step         <= 1'b1;
            per_cnt      <= DIV_W'(1);
            remaining    <= remaining - 1'b1;
            cur_position <= m_dir ? cur_position + 1'b1 : cur_position - 1'b1;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        RUN: begin
          if (abort) abort_pend <= 1'b1;
          if (per_cnt == PW) step <= 1'b0;
          if (per_cnt == divider) begin
            if (rem_eff == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              divider      <= next_div;
              ramp_cnt     <= next_ramp;
              remaining    <= rem_eff - 1'b1;
              step         <= 1'b1;
              per_cnt      <= DIV_W'(1);
              cur_position <= m_dir ? cur_position + 1'b1 : cur_position - 1'b1;
            end
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_profile_gen.sv
// tb/tb_step_profile_gen.sv - bench for step_profile_gen against a step-by-step motion profile model
// Step/done/dir activity is timestamped at negedge and compared per move after each batch.

module tb_step_profile_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [19:0] cmd_div_max = '0;
  logic        abort = 1'b0;
  logic        cmd_ready, step, dir, busy, done;
  logic [31:0] cur_position;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  step_profile_gen #(
    .DIV_START(1000), .DIV_DEC(100), .PULSE_W(4), .DIR_SETUP(8), .FIFO_DEPTH(4)
  ) dut (
    .CLK_50MHZ(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_div_max(cmd_div_max), .abort(abort),
    .step(step), .dir(dir), .cur_position(cur_position), .busy(busy), .done(done),
    .fifo_level(fifo_level)
  );

  int          cyc = 0;
  int          last_dir_t = 0;
  int          hw = 0;
  int          dw = 0;
  int          rise_q[$], sep_q[$], width_q[$], done_q[$], dwid_q[$], busy_q[$];
  logic [31:0] rpos_q[$];
  logic        rdir_q[$];
  logic        step_d = 1'b0, dir_d = 1'b0, done_d = 1'b0, busy_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (dir !== dir_d) last_dir_t = cyc;
    if (step === 1'b1 && step_d !== 1'b1) begin
      rise_q.push_back(cyc);
      rpos_q.push_back(cur_position);
      rdir_q.push_back(dir);
      sep_q.push_back(cyc - last_dir_t);
      hw = 1;
    end else if (step === 1'b1) begin
      hw++;
    end else if (step_d === 1'b1) begin
      width_q.push_back(hw);
    end
    if (done === 1'b1 && done_d !== 1'b1) begin
      done_q.push_back(cyc);
      dw = 1;
    end else if (done === 1'b1) begin
      dw++;
    end else if (done_d === 1'b1) begin
      dwid_q.push_back(dw);
    end
    if (busy === 1'b1 && busy_d !== 1'b1) busy_q.push_back(cyc);
    step_d = step;
    dir_d  = dir;
    done_d = done;
    busy_d = busy;
  end

  int          mv_steps[$], mv_dmax[$], mv_abort[$];
  logic        mv_dir[$];
  int          exp_per[$];
  logic [31:0] mpos = '0;
  logic        mdir = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Periods of one move, applying the ramp rules step by step on plain integers.
  task automatic model_move(input int steps, input int dmax, input int abort_at);
    int eff, d, ramp, rem;
    exp_per.delete();
    eff  = (dmax < 8) ? 8 : ((dmax > 1000) ? 1000 : dmax);
    d    = 1000;
    ramp = 0;
    rem  = steps;
    for (int k = 1; rem > 0; k++) begin
      exp_per.push_back(d);
      rem--;
      if (k == abort_at && ramp < rem) rem = ramp;
      if (rem > 0) begin
        if (rem <= ramp) begin
          d = (d + 100 > 1000) ? 1000 : d + 100;
          ramp--;
        end else if (d > eff) begin
          d = (d - 100 < eff) ? eff : d - 100;
          ramp++;
        end
      end
    end
  endtask

  task automatic clear_obs();
    rise_q.delete(); sep_q.delete(); width_q.delete(); done_q.delete();
    dwid_q.delete(); busy_q.delete(); rpos_q.delete(); rdir_q.delete();
  endtask

  task automatic record(input logic d, input int s, input int dm, input int ab);
    mv_dir.push_back(d);
    mv_steps.push_back(s);
    mv_dmax.push_back(dm);
    mv_abort.push_back(ab);
  endtask

  task automatic push(input logic d, input int s, input int dm, output logic ok);
    cmd_valid   = 1'b1;
    cmd_dir     = d;
    cmd_steps   = 16'(s);
    cmd_div_max = 20'(dm);
    #1 ok = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_move(input logic d, input int s, input int dm, input int ab);
    logic ok;
    push(d, s, dm, ok);
    chk($sformatf("accept s%0d", s), ok, 1);
    record(d, s, dm, ab);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    repeat (3) @(posedge clk);
    while ((busy !== 1'b0 || fifo_level !== 3'd0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("idle_within_budget", k < budget, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k;
    k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("reach_%0d_steps", n), rise_q.size() >= n, 1);
  endtask

  task automatic check_batch(input int nmoves);
    int ri, n, got, lim;
    ri = 0;
    chk("done_count", done_q.size(), nmoves);
    if (done_q.size() == nmoves) begin
      for (int m = 0; m < nmoves; m++) begin
        model_move(mv_steps[m], mv_dmax[m], mv_abort[m]);
        n = 0;
        while (ri + n < rise_q.size() && rise_q[ri+n] < done_q[m]) n++;
        chk($sformatf("step_count m%0d", m), n, exp_per.size());
        lim = (n < exp_per.size()) ? n : exp_per.size();
        for (int i = 0; i < lim; i++) begin
          got = (i + 1 < n) ? rise_q[ri+i+1] - rise_q[ri+i] : done_q[m] - rise_q[ri+i];
          chk($sformatf("period m%0d i%0d", m, i), got, exp_per[i]);
          mpos = mv_dir[m] ? mpos + 32'd1 : mpos - 32'd1;
          chk($sformatf("position m%0d i%0d", m, i), rpos_q[ri+i], mpos);
          chk($sformatf("dir_pin m%0d i%0d", m, i), rdir_q[ri+i], mv_dir[m]);
        end
        if (n > 0) begin
          if (mv_dir[m] != mdir) chk($sformatf("dir_setup m%0d", m), sep_q[ri], 8);
          mdir = mv_dir[m];
        end
        ri += n;
      end
    end
    foreach (width_q[i]) chk($sformatf("step_high %0d", i), width_q[i], 4);
    foreach (dwid_q[i]) chk($sformatf("done_width %0d", i), dwid_q[i], 1);
    clear_obs();
    mv_dir.delete(); mv_steps.delete(); mv_dmax.delete(); mv_abort.delete();
  endtask

  initial begin
    logic ok;
    logic d;
    int   s, dm, k;

    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_position", cur_position, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_obs();

    push_move(1'b1, 5, 700, 0);
    wait_idle(20000);
    check_batch(1);
    chk("t1_position", cur_position, 5);

    push_move(1'b0, 10, 800, 0);
    wait_idle(20000);
    check_batch(1);
    chk("t2_position", cur_position, 32'hFFFF_FFFB);

    d = 1'($urandom_range(0, 1)); s = $urandom_range(1, 5); dm = $urandom_range(0, 1100);
    push_move(d, s, dm, 0);
    k = 0;
    while (busy !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t3_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      d = 1'($urandom_range(0, 1)); s = $urandom_range(1, 5); dm = $urandom_range(0, 1100);
      push(d, s, dm, ok);
      if (i < 4) begin
        chk($sformatf("t3_accept %0d", i), ok, 1);
        chk($sformatf("t3_fifo_level %0d", i), fifo_level, i + 1);
        record(d, s, dm, 0);
      end else begin
        chk("t3_full_refused", ok, 0);
        chk("t3_fifo_level_full", fifo_level, 4);
      end
    end
    wait_idle(60000);
    check_batch(5);

    push_move(1'b1, 20, 500, 4);
    k = 0;
    while (busy !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    push(1'b0, 3, 300, ok);
    chk("t4_extra_queued", fifo_level, 1);
    wait_rises(4, 8000);
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    chk("t4_fifo_flushed", fifo_level, 0);
    chk("t4_ready_low_abort", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    wait_idle(20000);
    check_batch(1);

    push_move(1'b0, 0, 700, 0);
    wait_idle(100);
    chk("t5_zero_step_done", (done_q.size() == 1 && busy_q.size() > 0) ?
        done_q[0] - busy_q[busy_q.size()-1] : -1, 1);
    check_batch(1);

    push_move(1'b1, 24, 5, 0);
    wait_idle(20000);
    check_batch(1);

    push_move(1'b0, 3, 2000, 0);
    wait_idle(20000);
    check_batch(1);

    push_move(1'b1, 10, 500, 0);
    wait_rises(2, 5000);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_step", step, 0);
    chk("t5_rst_position", cur_position, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 1'b0;
    mv_dir.delete(); mv_steps.delete(); mv_dmax.delete(); mv_abort.delete();
    mpos = '0;
    mdir = 1'b0;
    @(negedge clk); #1;
    clear_obs();

    push_move(1'b0, 1, 700, 0);
    wait_idle(20000);
    check_batch(1);
    chk("t6_underflow", cur_position, 32'hFFFF_FFFF);
    push_move(1'b1, 2, 700, 0);
    wait_idle(20000);
    check_batch(1);
    chk("t6_wrap", cur_position, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
